// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch FSM encoding, halt word and processor mode defines
package fetch_stage_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        MODE_USER       = 2'd0,
        MODE_SUPERVISOR = 2'd1,
        MODE_MACHINE    = 2'd3
    } proc_mode_t;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {instruction, pc} entries with clear
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a push into a full queue is only legal when the head leaves the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch FSM feeding a prefetch queue
module fetch_stage #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk1,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_address,
    input  logic        mem_ack,
    input  logic [31:0] mem_read,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        halted
);
    import fetch_stage_pkg::*;

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_next;
    logic [63:0]   head;
    logic [63:0]   hold;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          push;
    logic          pop;
    logic          space_after_push;

    assign pop              = instr_valid && instr_ready && !flush;
    assign push             = (state == WAIT) && mem_ack && !flush;
    assign space_after_push = pop || (q_count < CW'(QDEPTH - 1));

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk       (clk1),
        .rst       (rst),
        .push      (push),
        .push_data ({mem_read, fetch_pc}),
        .pop       (pop),
        .clear     (flush),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // hold keeps the last presented head so the outputs stay stable while empty
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            hold     <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
            if (!q_empty) hold <= head;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        case (state)
            IDLE:  if (!q_full) state_next = REQ;
            REQ:   state_next = WAIT;
            WAIT: begin
                if (mem_ack) begin
                    pc_next = fetch_pc + PC_STEP;
                    if (mem_read == HALT_WORD)  state_next = HALT;
                    else if (space_after_push)  state_next = REQ;
                    else                        state_next = IDLE;
                end
            end
            DRAIN: if (mem_ack) state_next = REQ;
            HALT:  state_next = HALT;
            default: state_next = IDLE;
        endcase
        // an ack arriving with the flush retires the outstanding request, so no drain is needed
        if (flush) begin
            pc_next = align_word(flush_pc);
            if (state == REQ || ((state == WAIT || state == DRAIN) && !mem_ack))
                state_next = DRAIN;
            else
                state_next = REQ;
        end
    end

    assign mem_req     = (state == REQ);
    assign mem_address = fetch_pc;
    assign instr_valid = !q_empty;
    assign instr_out   = q_empty ? hold[63:32] : head[63:32];
    assign instr_pc    = q_empty ? hold[31:0]  : head[31:0];
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed memory responses
module tb_fetch_stage;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_address;
    logic        mem_ack;
    logic [31:0] mem_read;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_req [$];
    logic [63:0] exp_instr [$];
    logic [63:0] mon_e;

    always #5 clk1 = ~clk1;

    fetch_stage #(
        .QDEPTH   (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_address (mem_address),
        .mem_ack     (mem_ack),
        .mem_read    (mem_read),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: every request and every accepted head is compared against the scoreboard
    always @(negedge clk1) begin
        if (mem_req) begin
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got %h expected none", mem_address);
            end else begin
                check("req_addr", mem_address, exp_req.pop_front());
            end
        end
        if (instr_valid && instr_ready && !flush && !rst) begin
            if (exp_instr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %h@%h expected none", instr_out, instr_pc);
            end else begin
                mon_e = exp_instr.pop_front();
                check("pop_instr", instr_out, mon_e[63:32]);
                check("pop_pc", instr_pc, mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got mem_req=0 expected 1");
        end
    endtask

    task automatic ack(input logic [31:0] d);
        mem_ack  = 1'b1;
        mem_read = d;
        tick();
        mem_ack  = 1'b0;
    endtask

    task automatic serve(input logic [31:0] d);
        wait_req();
        tick();
        ack(d);
    endtask

    task automatic idle_no_req(input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            if (mem_req) seen++;
            tick();
        end
        check("no_req", 32'(seen), 32'd0);
    endtask

    task automatic check_reset();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_read = '0; flush = 1'b0; flush_pc = '0; instr_ready = 1'b0;
        repeat (3) tick();
        check_reset();

        // fill the queue with A..D while decode stalls
        rst = 1'b0;
        check("req_idle_cycle", {31'd0, mem_req}, 32'd0);
        exp_req.push_back(32'h0); exp_req.push_back(32'h4);
        exp_req.push_back(32'h8); exp_req.push_back(32'hC);
        tick();
        check("first_req", {31'd0, mem_req}, 32'd1);
        serve(32'hAAAA_0001);
        check("lat_valid", {31'd0, instr_valid}, 32'd1);
        check("lat_instr", instr_out, 32'hAAAA_0001);
        check("lat_pc", instr_pc, 32'h0);
        serve(32'hBBBB_0002);
        serve(32'hCCCC_0003);
        serve(32'hDDDD_0004);
        idle_no_req(6);
        check("full_head", instr_out, 32'hAAAA_0001);

        // drain in order; fetching resumes at 0x10
        exp_instr.push_back({32'hAAAA_0001, 32'h0});
        exp_instr.push_back({32'hBBBB_0002, 32'h4});
        exp_instr.push_back({32'hCCCC_0003, 32'h8});
        exp_instr.push_back({32'hDDDD_0004, 32'hC});
        exp_req.push_back(32'h10);
        instr_ready = 1'b1;
        repeat (4) tick();
        instr_ready = 1'b0;
        check("empty_valid", {31'd0, instr_valid}, 32'd0);
        check("hold_instr", instr_out, 32'hDDDD_0004);
        check("hold_pc", instr_pc, 32'hC);
        exp_req.push_back(32'h14);
        ack(32'hEEEE_0005);
        check("e_instr", instr_out, 32'hEEEE_0005);
        check("e_pc", instr_pc, 32'h10);
        wait_req();
        tick();

        // flush in WAIT, stale ack must vanish
        exp_req.push_back(32'h100);
        flush = 1'b1; flush_pc = 32'h103;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, instr_valid}, 32'd0);
        check("flush_hold", instr_out, 32'hEEEE_0005);
        check("drain_no_req", {31'd0, mem_req}, 32'd0);
        ack(32'hDEAD_BEEF);
        check("stale_valid", {31'd0, instr_valid}, 32'd0);
        exp_req.push_back(32'h104);
        serve(32'hF00D_0006);
        check("f_pc", instr_pc, 32'h100);
        wait_req();
        tick();

        // flush, ack and pending pop together
        exp_req.push_back(32'h0);
        instr_ready = 1'b1; flush = 1'b1; flush_pc = 32'h0; mem_ack = 1'b1; mem_read = 32'h1234_5678;
        tick();
        instr_ready = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        check("fa_valid", {31'd0, instr_valid}, 32'd0);
        check("fa_hold", instr_out, 32'hF00D_0006);

        // halt word at 0x8
        exp_req.push_back(32'h4); exp_req.push_back(32'h8);
        serve(32'h1111_0001);
        serve(32'h2222_0002);
        serve(32'h0000_0000);
        check("halted_set", {31'd0, halted}, 32'd1);
        idle_no_req(8);
        ack(32'h5555_0005);
        check("halted_hold", {31'd0, halted}, 32'd1);
        exp_instr.push_back({32'h1111_0001, 32'h0});
        exp_instr.push_back({32'h2222_0002, 32'h4});
        exp_instr.push_back({32'h0000_0000, 32'h8});
        instr_ready = 1'b1;
        repeat (3) tick();
        instr_ready = 1'b0;
        check("halt_ack_ignored", {31'd0, instr_valid}, 32'd0);
        exp_req.push_back(32'h0);
        flush = 1'b1; flush_pc = 32'h0;
        tick();
        flush = 1'b0;
        check("halted_clear", {31'd0, halted}, 32'd0);
        wait_req();
        tick();

        // reset during WAIT overrides flush and ack
        rst = 1'b1; mem_ack = 1'b1; mem_read = 32'h7777_0007; flush = 1'b1; flush_pc = 32'h200;
        tick();
        rst = 1'b0; mem_ack = 1'b0; flush = 1'b0;
        check_reset();
        exp_req.push_back(32'h0);
        tick();
        check("rst_first_req", {31'd0, mem_req}, 32'd1);
        exp_req.push_back(32'h4);
        exp_instr.push_back({32'h9999_0009, 32'h0});
        instr_ready = 1'b1;
        serve(32'h9999_0009);
        tick();
        instr_ready = 1'b0;

        // address wrap at the top of the space
        exp_req.push_back(32'hFFFF_FFFC);
        flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0;
        ack(32'h4444_0004);
        exp_req.push_back(32'h0);
        exp_instr.push_back({32'hABCD_0010, 32'hFFFF_FFFC});
        instr_ready = 1'b1;
        serve(32'hABCD_0010);
        tick();
        instr_ready = 1'b0;
        repeat (2) tick();
        check("req_left", 32'(exp_req.size()), 32'd0);
        check("instr_left", 32'(exp_instr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
